// File: rtl/copro_ctrl_pkg.sv
// Shared types and constants for the copro AXI4-Lite control path.
package copro_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int COPRO_NUM_REGS = 4;
    localparam int COPRO_ADDR_W   = 4;

endpackage

// File: rtl/copro_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the requester after the last winner.
module copro_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] last_reg;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_idx = IDX_W'((int'(last_reg) + i) % NUM_REQ);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    // Reset parks the pointer on the last requester so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= IDX_W'(NUM_REQ - 1);
        end else if (advance && found) begin
            last_reg <= grant_idx;
        end
    end

endmodule

// File: rtl/copro_axil_sequencer.sv
// Arbitrates single-word commands from NUM_REQ requesters onto one AXI4-Lite master port.
module copro_axil_sequencer
    import copro_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       s00_axi_aclk,
    input  logic                       s00_axi_aresetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [1:0]                 rsp_resp,
    output logic                       busy,
    output logic [15:0]                txn_count,
    output logic [ADDR_W-1:0]          m_axi_awaddr,
    output logic [2:0]                 m_axi_awprot,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [DATA_W-1:0]          m_axi_wdata,
    output logic [3:0]                 m_axi_wstrb,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [ADDR_W-1:0]          m_axi_araddr,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [DATA_W-1:0]          m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    seq_state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;

    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [IDX_W-1:0]  owner_reg;
    logic              awvalid_reg;
    logic              wvalid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic [1:0]        rsp_resp_reg;
    logic [15:0]       txn_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = accept && grant[gi];
            assign rsp_valid[gi] = (state_reg == ST_DONE) && (owner_reg == IDX_W'(gi));
        end
    endgenerate

    // Gated by reset so no ready pulse leaks out while the block is held in reset.
    assign accept = s00_axi_aresetn && (state_reg == ST_IDLE) && (|req_valid);

    copro_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (s00_axi_aclk),
        .rst_n     (s00_axi_aresetn),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = req_we[grant_idx] ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: begin
                if ((!awvalid_reg || m_axi_awready) && (!wvalid_reg || m_axi_wready)) begin
                    state_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: if (m_axi_bvalid)  state_next = ST_DONE;
            ST_RD_ADDR: if (m_axi_arready) state_next = ST_RD_DATA;
            ST_RD_DATA: if (m_axi_rvalid)  state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            addr_reg      <= '0;
            wdata_reg     <= '0;
            owner_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= AXI_RESP_OKAY;
            txn_count_reg <= '0;
        end else begin
            if (accept) begin
                addr_reg    <= addr_arr[grant_idx] & ~ADDR_W'(3);
                wdata_reg   <= wdata_arr[grant_idx];
                owner_reg   <= grant_idx;
                awvalid_reg <= req_we[grant_idx];
                wvalid_reg  <= req_we[grant_idx];
            end else if (state_reg == ST_WR_ADDR) begin
                // AW and W retire independently; either may finish first.
                if (awvalid_reg && m_axi_awready) awvalid_reg <= 1'b0;
                if (wvalid_reg && m_axi_wready)   wvalid_reg  <= 1'b0;
            end
            if (state_reg == ST_WR_RESP && m_axi_bvalid) begin
                rsp_rdata_reg <= '0;
                rsp_resp_reg  <= m_axi_bresp;
            end
            if (state_reg == ST_RD_DATA && m_axi_rvalid) begin
                rsp_rdata_reg <= m_axi_rdata;
                rsp_resp_reg  <= m_axi_rresp;
            end
            if (state_reg == ST_DONE) begin
                txn_count_reg <= txn_count_reg + 16'd1;
            end
        end
    end

    assign busy          = (state_reg != ST_IDLE);
    assign txn_count     = txn_count_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_araddr  = addr_reg;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = (state_reg == ST_WR_RESP);
    assign m_axi_arvalid = (state_reg == ST_RD_ADDR);
    assign m_axi_rready  = (state_reg == ST_RD_DATA);

endmodule

// File: tb/tb_copro_axil_sequencer.sv
// Directed bench: behavioural AXI-Lite slave, transaction-level reference model and per-cycle compare.
module tb_copro_axil_sequencer;

    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NR*4-1:0]  req_addr;
    logic [NR*32-1:0] req_wdata;
    logic [31:0]      rsp_rdata;
    logic [1:0]       rsp_resp;
    logic             busy;
    logic [15:0]      txn_count;
    logic [3:0]       awaddr, araddr;
    logic [2:0]       awprot, arprot;
    logic             awvalid, awready, wvalid, wready, bvalid, bready;
    logic             arvalid, arready, rvalid, rready;
    logic [31:0]      wdata, rdata;
    logic [3:0]       wstrb;
    logic [1:0]       bresp, rresp;

    copro_axil_sequencer #(.NUM_REQ(NR), .ADDR_W(4), .DATA_W(32)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_resp        (rsp_resp),
        .busy            (busy),
        .txn_count       (txn_count),
        .m_axi_awaddr    (awaddr),
        .m_axi_awprot    (awprot),
        .m_axi_awvalid   (awvalid),
        .m_axi_awready   (awready),
        .m_axi_wdata     (wdata),
        .m_axi_wstrb     (wstrb),
        .m_axi_wvalid    (wvalid),
        .m_axi_wready    (wready),
        .m_axi_bresp     (bresp),
        .m_axi_bvalid    (bvalid),
        .m_axi_bready    (bready),
        .m_axi_araddr    (araddr),
        .m_axi_arprot    (arprot),
        .m_axi_arvalid   (arvalid),
        .m_axi_arready   (arready),
        .m_axi_rdata     (rdata),
        .m_axi_rresp     (rresp),
        .m_axi_rvalid    (rvalid),
        .m_axi_rready    (rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Slave configuration and observation counters.
    int         aw_delay = 0;
    int         w_delay  = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic       stall_r = 1'b0;
    int         aw_cnt = 0, w_cnt = 0, ar_cnt = 0, dup_cnt = 0;

    logic [31:0] slave_mem [4];
    logic [31:0] model_mem [4];

    // Behavioural AXI-Lite slave; all updates happen 1 ns after the rising edge.
    initial begin : slave
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, r_pend;
        int aw_wait, w_wait;
        logic [3:0]  wa, ra, awaddr_s, araddr_s;
        logic [31:0] wd, wdata_s;
        for (int i = 0; i < 4; i++) slave_mem[i] = 32'h0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_got = 0; w_got = 0; r_pend = 0; aw_wait = 0; w_wait = 0;
        wa = 0; ra = 0; awaddr_s = 0; araddr_s = 0; wd = 0; wdata_s = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rdata = 0; rresp = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_got = 0; w_got = 0; r_pend = 0; aw_wait = 0; w_wait = 0;
                continue;
            end
            if (b_hs) begin
                bvalid = 0; aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
            end
            if (aw_hs) begin aw_got = 1; aw_cnt++; wa = awaddr_s; end
            if (w_hs)  begin w_got = 1; w_cnt++; wd = wdata_s; end
            if (r_hs) rvalid = 0;
            if (ar_hs) begin ar_cnt++; ra = araddr_s; r_pend = 1; end
            if (r_pend && !stall_r) begin
                rvalid = 1; rdata = slave_mem[ra[3:2]]; rresp = 2'b00; r_pend = 0;
            end
            if (aw_got && w_got && !bvalid) begin
                slave_mem[wa[3:2]] = wd; bvalid = 1; bresp = bresp_cfg;
            end
            if (awvalid && aw_got) dup_cnt++;
            if (wvalid && w_got)   dup_cnt++;
            awready = awvalid && !aw_got && (aw_wait >= aw_delay);
            if (awvalid && !aw_got && !awready) aw_wait++;
            wready = wvalid && !w_got && (w_wait >= w_delay);
            if (wvalid && !w_got && !wready) w_wait++;
            arready = arvalid;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            awaddr_s = awaddr; wdata_s = wdata; araddr_s = araddr;
            if (aw_hs) check("awprot", 32'(awprot), 32'h0);
            if (w_hs)  check("wstrb", 32'(wstrb), 32'hF);
            if (ar_hs) check("arprot", 32'(arprot), 32'h0);
        end
    end

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t exp_q[$];

    // Transaction-level reference: RR grant, register contents, responses, completion count.
    initial begin : compare
        int m_last, m_count, c, gsel;
        bit m_idle, idle_pend;
        logic [NR-1:0] exp_ready;
        exp_t e;
        for (int i = 0; i < 4; i++) model_mem[i] = 32'h0;
        m_last = NR - 1; m_count = 0; m_idle = 1; idle_pend = 0; gsel = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_last = NR - 1; m_count = 0; m_idle = 1; idle_pend = 0;
                exp_q.delete();
                check("reset_ctrl", 32'({req_ready, rsp_valid, busy, awvalid, wvalid,
                                         arvalid, bready, rready}), 32'h0);
                check("reset_txn_count", 32'(txn_count), 32'h0);
                check("reset_rsp", {rsp_rdata[31:2], rsp_rdata[1:0] | rsp_resp}, 32'h0);
                check("reset_axi_data", wdata | 32'({awaddr, araddr}), 32'h0);
                continue;
            end
            if (idle_pend) begin m_idle = 1; idle_pend = 0; end
            check("busy", 32'(busy), 32'(!m_idle));
            check("txn_count", 32'(txn_count), 32'(m_count[15:0]));
            exp_ready = '0;
            if (m_idle && req_valid != '0) begin
                for (int i = 1; i <= NR; i++) begin
                    c = (m_last + i) % NR;
                    if (req_valid[c]) begin
                        gsel = c;
                        exp_ready[c] = 1'b1;
                        break;
                    end
                end
            end
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            if (exp_ready != '0) begin
                m_last = gsel;
                m_idle = 0;
                e.owner = gsel;
                c = int'(req_addr[gsel*4+2 +: 2]);
                if (req_we[gsel]) begin
                    model_mem[c] = req_wdata[gsel*32 +: 32];
                    e.rdata = 32'h0;
                    e.resp  = bresp_cfg;
                end else begin
                    e.rdata = model_mem[c];
                    e.resp  = 2'b00;
                end
                exp_q.push_back(e);
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(1 << e.owner));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    $display("txn %0d: owner=%0d rdata=0x%08h resp=%0d",
                             m_count, e.owner, rsp_rdata, rsp_resp);
                end
                m_count++;
                idle_pend = 1;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #200;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input int r, input logic we, input logic [3:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] rs);
        int n;
        rd = 32'hDEAD_BEEF; rs = 2'b11;
        @(posedge clk); #1;
        req_we[r] = we; req_addr[r*4 +: 4] = addr; req_wdata[r*32 +: 32] = wd;
        req_valid[r] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[r] && n < 50);
        if (!req_ready[r]) check("issue_grant_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid[r] && n < 100);
        if (!rsp_valid[r]) check("issue_rsp_timeout", 32'(n), 32'(0));
        else begin rd = rsp_rdata; rs = rsp_resp; end
    endtask

    task automatic run_contention();
        int g[6];
        int n, cyc;
        n = 0; cyc = 0;
        for (int i = 0; i < 6; i++) g[i] = -1;
        @(posedge clk); #1;
        req_we = '0; req_addr = {4'h4, 4'h0}; req_valid = 2'b11;
        while (n < 6 && cyc < 300) begin
            @(negedge clk); cyc++;
            if (req_ready != '0) begin g[n] = req_ready[1] ? 1 : 0; n++; end
        end
        @(posedge clk); #1;
        req_valid = '0;
        check("cont_grant_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("cont_grant%0d", i), 32'(g[i]), 32'(i % 2));
        repeat (20) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] rd;
        logic [1:0]  rs;
        int a0, w0, d0, n, seen;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        do_reset();
        @(negedge clk);
        check("init_busy", 32'(busy), 32'h0);
        check("init_txn_count", 32'(txn_count), 32'h0);
        check("init_rsp_valid", 32'(rsp_valid), 32'h0);

        issue(0, 1'b1, 4'h0, 32'h0000_0001, rd, rs);
        check("t1_wr_resp", 32'(rs), 32'h0);
        check("t1_wr_rdata", rd, 32'h0);
        issue(0, 1'b0, 4'h0, 32'h0, rd, rs);
        check("t1_rd_data", rd, 32'h0000_0001);
        check("t1_rd_resp", 32'(rs), 32'h0);
        @(negedge clk);
        check("t1_txn_count", 32'(txn_count), 32'd2);

        do_reset();
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 4'(i * 4), 32'(i + 1), rd, rs);
        for (int i = 0; i < 4; i++) begin
            issue(1, 1'b0, 4'(i * 4), 32'h0, rd, rs);
            check($sformatf("fill_rd%0d", i), rd, 32'(i + 1));
        end
        @(negedge clk);
        check("fill_txn_count", 32'(txn_count), 32'd8);

        do_reset();
        run_contention();

        aw_delay = 3; w_delay = 0;
        a0 = aw_cnt; w0 = w_cnt; d0 = dup_cnt;
        issue(0, 1'b1, 4'h8, 32'hA5A5_0001, rd, rs);
        check("skew1_aw_cnt", 32'(aw_cnt - a0), 32'd1);
        check("skew1_w_cnt", 32'(w_cnt - w0), 32'd1);
        check("skew1_dup", 32'(dup_cnt - d0), 32'd0);
        aw_delay = 0; w_delay = 3;
        a0 = aw_cnt; w0 = w_cnt; d0 = dup_cnt;
        issue(1, 1'b1, 4'hC, 32'h5A5A_0002, rd, rs);
        check("skew2_aw_cnt", 32'(aw_cnt - a0), 32'd1);
        check("skew2_w_cnt", 32'(w_cnt - w0), 32'd1);
        check("skew2_dup", 32'(dup_cnt - d0), 32'd0);
        w_delay = 0;
        issue(0, 1'b0, 4'h9, 32'h0, rd, rs);
        check("skew_readback", rd, 32'hA5A5_0001);

        bresp_cfg = 2'b10;
        issue(0, 1'b1, 4'h4, 32'h0000_0055, rd, rs);
        check("slverr_resp", 32'(rs), 32'h2);
        bresp_cfg = 2'b00;

        stall_r = 1'b1;
        a0 = ar_cnt;
        @(posedge clk); #1;
        req_we[0] = 1'b0; req_addr[3:0] = 4'h0; req_valid[0] = 1'b1;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (ar_cnt == a0 && n < 50);
        req_valid[0] = 1'b0;
        check("midop_ar_seen", 32'(ar_cnt - a0), 32'd1);
        check("midop_in_rd_data", 32'(rready), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("midop_reset_valids", 32'({awvalid, wvalid, arvalid, rready, bready, busy}), 32'h0);
        check("midop_reset_rsp", 32'({rsp_valid, req_ready}), 32'h0);
        seen = 0;
        repeat (20) begin @(negedge clk); if (rsp_valid != '0) seen++; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall_r = 1'b0;
        repeat (10) begin @(negedge clk); if (rsp_valid != '0) seen++; end
        check("midop_no_rsp", 32'(seen), 32'h0);
        issue(1, 1'b0, 4'h0, 32'h0, rd, rs);
        check("midop_recover_rd", rd, 32'h0000_0001);
        @(negedge clk);
        check("midop_recover_count", 32'(txn_count), 32'd1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/copro_axil_sequencer.md
Name: copro_axil_sequencer

Overview:
Shares the copro AXI4-Lite slave register file (four 32-bit registers, byte offsets 0x0/0x4/0x8/0xC) between NUM_REQ local requesters. It arbitrates single-word read/write commands round-robin and drives exactly one AXI4-Lite master transaction at a time toward the copro slave. It returns read data and response status to the requester that issued the command. It sits in the PL between control logic (FSMs, DMA-side glue) and the copro AXI slave port.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 4, AXI address width in bits (byte address)
DATA_W, 32, AXI data width; fixed at 32

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  command pending, one bit per requester
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed byte addresses
req_wdata  in  NUM_REQ*DATA_W  packed write data
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owner
rsp_rdata  out  DATA_W  read data; valid with rsp_valid, 0 for writes
rsp_resp  out  2  AXI BRESP/RRESP of the completed transaction
busy  out  1  high in every state except IDLE
txn_count  out  16  completed transactions; wraps 0xFFFF->0
m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_W/3/1/1  AW channel
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  W channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel
m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_W/3/1/1  AR channel
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  R channel

Behaviour:
- Reset (async assert, sync deassert by the environment): state IDLE. All valid, ready, and rsp outputs are 0. awaddr/araddr/wdata/rsp_rdata are 0; rsp_resp is 2'b00; txn_count is 0. The RR pointer is set so that requester 0 has the highest priority. A reset mid-transaction abandons the transaction with no response pulse.
- Constants: awprot and arprot are 3'b000. wstrb is 4'hF. The low 2 address bits are forced to 0.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: if any req_valid is set, pick the winner g round-robin, starting from the requester after the last winner.
  - req_ready[g] = 1 combinationally in this cycle only.
  - Latch we/addr/wdata and the owner index at the clock edge.
  - Go to WR_ADDR if we=1, otherwise RD_ADDR.
  - Update the pointer so g has the lowest priority next time.
- WR_ADDR: awvalid and wvalid both rise on entry. Each drops independently on its own ready handshake; the two handshakes may complete in the same cycle or in either order. When both are done, go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, capture bresp and go to DONE.
- RD_ADDR: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, capture rdata and rresp and go to DONE.
- DONE: rsp_valid[owner] = 1 for one cycle. rsp_rdata/rsp_resp hold their values until the next DONE. txn_count increments. Return to IDLE.
- Latency with an always-ready slave that responds one cycle after the handshake:
  - write: accept edge to rsp_valid = 4 cycles
  - read: accept edge to rsp_valid = 4 cycles
  - back-to-back commands: 1 idle cycle between transactions
- No timeout: the FSM waits indefinitely for the slave.
- A requester that drops req_valid before its grant is simply skipped.
- req_valid held through DONE is not re-granted until IDLE.
- SLVERR/DECERR responses are passed through on rsp_resp; the transaction still completes normally.
- txn_count wraps silently.

Decomposition:
- Package copro_ctrl_pkg:
  - seq_state_t enum
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - COPRO_NUM_REGS=4, COPRO_ADDR_W=4
- Sub-module copro_rr_arbiter:
  - NUM_REQ-wide request vector in, one-hot grant out
  - pointer register with advance enable

Test Plan:
- Reset: hold s00_axi_aresetn low for 200 ns, then release. All outputs must be 0, busy=0, txn_count=0.
- Single write then read: req0 writes 0x00000001 to 0x0, then reads 0x0. The read gives rsp_valid[0] with rsp_rdata=0x00000001 and rsp_resp=00; txn_count=2.
- Sequential fill: req1 writes 0x1..0x4 to 0x0/0x4/0x8/0xC, then reads all four back. Each readback matches; txn_count=8.
- Contention: req0 and req1 both held valid for 6 transactions. Grants alternate 0,1,0,1,0,1, and no requester gets two consecutive grants.
- Channel skew: the slave delays awready by 3 cycles and wready by 0, then the reverse. Exactly one AW and one W handshake occur, with no duplicate awvalid or wvalid.
- Error and reset mid-op: the slave returns bresp=10, which gives rsp_resp=10. Asserting reset while in RD_DATA forces IDLE, no rsp_valid, and all valid outputs low.
